// File: rtl/gcd_tb_pkg.sv
// -----------------------------------------------------------------------------
// gcd_tb_pkg
// Shared definitions for the GCD stimulus controller and its LFSR:
//   state_t    - controller state encoding
//   LFSR_SEED  - value the 6-bit LFSR takes on reset
//   TAP_LO/HI  - feedback tap indices, fb = s[TAP_LO] ^ s[TAP_HI]
// -----------------------------------------------------------------------------
package gcd_tb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL_A = 3'd1,
    FILL_B = 3'd2,
    ISSUE  = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [5:0] LFSR_SEED = 6'b111111;
  localparam int         TAP_LO    = 1;
  localparam int         TAP_HI    = 4;

endpackage

// File: rtl/lfsr6_en.sv
// -----------------------------------------------------------------------------
// lfsr6_en
// 6-bit right-shifting LFSR with a step enable. The new bit enters at s[5]
// and the output bit is the current s[0].
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low; loads LFSR_SEED
//   en     - advance one step on this clock edge
//   q      - output bit, s[0]
// -----------------------------------------------------------------------------
module lfsr6_en
  import gcd_tb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic q
);

  logic [5:0] s;
  logic       fb;

  assign fb = s[TAP_LO] ^ s[TAP_HI];
  assign q  = s[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s <= LFSR_SEED;
    end else if (en) begin
      s <= {fb, s[5:1]};
    end
  end

endmodule

// File: rtl/gcd_stim_ctrl.sv
// -----------------------------------------------------------------------------
// gcd_stim_ctrl
// Stimulus sequencer for a GCD unit. Builds operand pairs from an LFSR bit
// stream, issues each pair with a one-cycle gcd_start, waits for gcd_done
// (bounded by TIMEOUT cycles), captures the result and repeats until
// NUM_TESTS results have been collected or a wait times out.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   start             - run request, honoured only in IDLE or DONE
//   gcd_done          - DUT completion strobe, honoured only in WAIT
//   gcd_result        - DUT result, valid with gcd_done
//   op_a, op_b        - operands, change only when entering ISSUE
//   gcd_start         - one-cycle pulse while in ISSUE
//   result            - last captured gcd_result
//   result_valid      - one-cycle pulse in the cycle after gcd_done accepted
//   test_cnt          - completed tests in the current run
//   busy              - high in FILL_A, FILL_B, ISSUE, WAIT
//   all_done          - high in DONE
//   timeout_err       - sticky until the next start; set on WAIT timeout
// -----------------------------------------------------------------------------
module gcd_stim_ctrl
  import gcd_tb_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int NUM_TESTS = 16,
  parameter  int TIMEOUT   = 255,
  localparam int CNT_W     = $clog2(NUM_TESTS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             gcd_start,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [CNT_W-1:0] test_cnt,
  output logic             busy,
  output logic             all_done,
  output logic             timeout_err
);

  localparam int FILL_W = $clog2(WIDTH);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [FILL_W-1:0] FILL_LAST   = FILL_W'(WIDTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  NUM_TESTS_C = CNT_W'(NUM_TESTS);

  state_t            state;
  logic [FILL_W-1:0] fill_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WIDTH-1:0]  asm_a;
  logic [WIDTH-1:0]  asm_b;
  logic [WIDTH-1:0]  asm_b_next;
  logic [CNT_W-1:0]  cnt_next;
  logic              q;
  logic              lfsr_en;

  // A zero operand would never terminate a subtractive GCD; present 1 instead.
  function automatic logic [WIDTH-1:0] zero_guard(input logic [WIDTH-1:0] v);
    return (v == '0) ? WIDTH'(1) : v;
  endfunction

  assign lfsr_en = (state == FILL_A) || (state == FILL_B);

  // op_b must include the bit shifted in on the very edge that enters ISSUE.
  assign asm_b_next = {q, asm_b[WIDTH-1:1]};
  assign cnt_next   = test_cnt + CNT_W'(1);

  lfsr6_en u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .q     (q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      fill_cnt     <= '0;
      wait_cnt     <= '0;
      asm_a        <= '0;
      asm_b        <= '0;
      op_a         <= '0;
      op_b         <= '0;
      result       <= '0;
      gcd_start    <= 1'b0;
      result_valid <= 1'b0;
      test_cnt     <= '0;
      busy         <= 1'b0;
      all_done     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      gcd_start    <= 1'b0;
      result_valid <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= FILL_A;
            fill_cnt    <= '0;
            test_cnt    <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            all_done    <= 1'b0;
          end
        end

        FILL_A: begin
          asm_a <= {q, asm_a[WIDTH-1:1]};
          if (fill_cnt == FILL_LAST) begin
            fill_cnt <= '0;
            state    <= FILL_B;
          end else begin
            fill_cnt <= fill_cnt + FILL_W'(1);
          end
        end

        FILL_B: begin
          asm_b <= asm_b_next;
          if (fill_cnt == FILL_LAST) begin
            fill_cnt  <= '0;
            state     <= ISSUE;
            gcd_start <= 1'b1;
            op_a      <= zero_guard(asm_a);
            op_b      <= zero_guard(asm_b_next);
          end else begin
            fill_cnt <= fill_cnt + FILL_W'(1);
          end
        end

        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end

        WAIT: begin
          // gcd_done takes priority over a timeout in the same cycle.
          if (gcd_done) begin
            result       <= gcd_result;
            result_valid <= 1'b1;
            test_cnt     <= cnt_next;
            if (cnt_next == NUM_TESTS_C) begin
              state    <= DONE;
              busy     <= 1'b0;
              all_done <= 1'b1;
            end else begin
              state    <= FILL_A;
              fill_cnt <= '0;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            state       <= DONE;
            busy        <= 1'b0;
            all_done    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          all_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_stim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gcd_stim_ctrl
// Directed bench for gcd_stim_ctrl. u_dut (WIDTH=4, NUM_TESTS=2, TIMEOUT=5)
// covers sequencing, capture, timeout, spurious inputs and async reset.
// u_dut2 (WIDTH=2) exercises the zero-operand guard: its 4th pair of LFSR
// bits is 0,0.
// Expected LFSR bit stream from seed 6'b111111:
//   1111 1100 1101 0010 0001 0101 ...
// giving WIDTH=4 pairs F/3, B/4, 8/A and WIDTH=2 pairs 3/3, 3/0->1.
// -----------------------------------------------------------------------------
module tb_gcd_stim_ctrl;

  localparam int W  = 4;
  localparam int W2 = 2;

  logic          clk = 1'b0;
  logic          reset, start, gcd_done;
  logic [W-1:0]  gcd_result, op_a, op_b, result;
  logic          gcd_start, result_valid, busy, all_done, timeout_err;
  logic [1:0]    test_cnt;

  logic          reset2, start2, gcd_done2;
  logic [W2-1:0] gcd_result2, op_a2, op_b2, result2;
  logic          gcd_start2, result_valid2, busy2, all_done2, timeout_err2;
  logic [1:0]    test_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gcd_stim_ctrl #(.WIDTH(W), .NUM_TESTS(2), .TIMEOUT(5)) u_dut (
    .clk(clk), .reset(reset), .start(start), .gcd_done(gcd_done),
    .gcd_result(gcd_result), .op_a(op_a), .op_b(op_b), .gcd_start(gcd_start),
    .result(result), .result_valid(result_valid), .test_cnt(test_cnt),
    .busy(busy), .all_done(all_done), .timeout_err(timeout_err)
  );

  gcd_stim_ctrl #(.WIDTH(W2), .NUM_TESTS(2), .TIMEOUT(5)) u_dut2 (
    .clk(clk), .reset(reset2), .start(start2), .gcd_done(gcd_done2),
    .gcd_result(gcd_result2), .op_a(op_a2), .op_b(op_b2), .gcd_start(gcd_start2),
    .result(result2), .result_valid(result_valid2), .test_cnt(test_cnt2),
    .busy(busy2), .all_done(all_done2), .timeout_err(timeout_err2)
  );

  // Called at a negedge; returns in cycle 1 of the run.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles until gcd_start, starting from cycle n0; bounded.
  task automatic wait_issue(input int n0, output int n);
    n = n0;
    while (gcd_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; reset2 = 1'b0;
    start = 1'b0; gcd_done = 1'b0; gcd_result = '0;
    start2 = 1'b0; gcd_done2 = 1'b0; gcd_result2 = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (all_done !== 1'b0) begin n_bad++; $display("FAIL reset_all_done: got %b expected 0", all_done); end
    n_cmp++; if ({op_a, op_b, result} !== 12'h000) begin n_bad++; $display("FAIL reset_data: got %h expected 000", {op_a, op_b, result}); end
    n_cmp++; if ({gcd_start, result_valid, timeout_err, test_cnt} !== 5'b0) begin n_bad++; $display("FAIL reset_ctrl: got %b expected 00000", {gcd_start, result_valid, timeout_err, test_cnt}); end
    reset = 1'b1; reset2 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n;
    pulse_start();
    wait_issue(1, n);
    n_cmp++; if (n != 9) begin n_bad++; $display("FAIL first_issue_cycle: got %0d expected 9", n); end
    n_cmp++; if (op_a !== 4'hF) begin n_bad++; $display("FAIL first_op_a: got %h expected f", op_a); end
    n_cmp++; if (op_b !== 4'h3) begin n_bad++; $display("FAIL first_op_b: got %h expected 3", op_b); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL issue_busy: got %b expected 1", busy); end
    repeat (4) @(negedge clk);
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL rv_before_done: got %b expected 0", result_valid); end
    gcd_done = 1'b1; gcd_result = 4'h3;
    @(negedge clk);
    gcd_done = 1'b0;
    n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL rv_pulse: got %b expected 1", result_valid); end
    n_cmp++; if (result !== 4'h3) begin n_bad++; $display("FAIL result_capture: got %h expected 3", result); end
    n_cmp++; if (test_cnt !== 2'd1) begin n_bad++; $display("FAIL cnt_after_1: got %0d expected 1", test_cnt); end
    // FILL_A cycle 2: spurious gcd_done
    @(negedge clk);
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL rv_one_cycle: got %b expected 0", result_valid); end
    gcd_done = 1'b1; gcd_result = 4'h9;
    @(negedge clk);
    gcd_done = 1'b0;
    n_cmp++; if ({result_valid, test_cnt, result} !== {1'b0, 2'd1, 4'h3}) begin n_bad++; $display("FAIL spurious_done: got %b/%0d/%h expected 0/1/3", result_valid, test_cnt, result); end
    wait_issue(3, n);
    n_cmp++; if (n != 9) begin n_bad++; $display("FAIL second_issue_cycle: got %0d expected 9", n); end
    n_cmp++; if (op_a !== 4'hB) begin n_bad++; $display("FAIL second_op_a: got %h expected b", op_a); end
    n_cmp++; if (op_b !== 4'h4) begin n_bad++; $display("FAIL second_op_b: got %h expected 4", op_b); end
    // start during WAIT must be ignored
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if ({busy, all_done, test_cnt} !== {1'b1, 1'b0, 2'd1}) begin n_bad++; $display("FAIL start_in_wait: got %b/%b/%0d expected 1/0/1", busy, all_done, test_cnt); end
    repeat (2) @(negedge clk);
    gcd_done = 1'b1; gcd_result = 4'h1;
    @(negedge clk);
    gcd_done = 1'b0;
    n_cmp++; if ({result_valid, result, test_cnt} !== {1'b1, 4'h1, 2'd2}) begin n_bad++; $display("FAIL second_capture: got %b/%h/%0d expected 1/1/2", result_valid, result, test_cnt); end
    n_cmp++; if ({all_done, busy} !== 2'b10) begin n_bad++; $display("FAIL run_done: got %b expected 10", {all_done, busy}); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({all_done, busy, test_cnt, result_valid} !== {1'b1, 1'b0, 2'd2, 1'b0}) begin n_bad++; $display("FAIL done_hold: got %b expected 10100", {all_done, busy, test_cnt, result_valid}); end
  endtask

  task automatic test_timeout();
    int n, k;
    pulse_start();
    n_cmp++; if ({test_cnt, all_done, busy} !== {2'd0, 1'b0, 1'b1}) begin n_bad++; $display("FAIL restart_clear: got %b expected 0001", {test_cnt, all_done, busy}); end
    wait_issue(1, n);
    n_cmp++; if (n != 9) begin n_bad++; $display("FAIL third_issue_cycle: got %0d expected 9", n); end
    n_cmp++; if ({op_a, op_b} !== 8'h8A) begin n_bad++; $display("FAIL third_ops: got %h expected 8a", {op_a, op_b}); end
    k = 0;
    @(negedge clk);
    while (busy === 1'b1 && k < 20) begin
      k++;
      @(negedge clk);
    end
    n_cmp++; if (k != 5) begin n_bad++; $display("FAIL wait_cycles: got %0d expected 5", k); end
    n_cmp++; if ({timeout_err, all_done, test_cnt} !== {1'b1, 1'b1, 2'd0}) begin n_bad++; $display("FAIL timeout_flags: got %b expected 1100", {timeout_err, all_done, test_cnt}); end
    n_cmp++; if ({result_valid, result} !== {1'b0, 4'h1}) begin n_bad++; $display("FAIL timeout_result: got %b/%h expected 0/1", result_valid, result); end
    pulse_start();
    n_cmp++; if ({timeout_err, busy} !== 2'b01) begin n_bad++; $display("FAIL timeout_clear: got %b expected 01", {timeout_err, busy}); end
  endtask

  task automatic test_coincident();
    int n;
    wait_issue(1, n);
    n_cmp++; if (n != 9) begin n_bad++; $display("FAIL coinc_issue_cycle: got %0d expected 9", n); end
    repeat (5) @(negedge clk);
    gcd_done = 1'b1; gcd_result = 4'h5;
    @(negedge clk);
    gcd_done = 1'b0;
    n_cmp++; if ({result_valid, result, test_cnt} !== {1'b1, 4'h5, 2'd1}) begin n_bad++; $display("FAIL coinc_capture: got %b/%h/%0d expected 1/5/1", result_valid, result, test_cnt); end
    n_cmp++; if ({timeout_err, busy} !== 2'b01) begin n_bad++; $display("FAIL coinc_no_timeout: got %b expected 01", {timeout_err, busy}); end
  endtask

  task automatic test_async_reset();
    int n;
    wait_issue(1, n);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    n_cmp++; if ({op_a, op_b, result, test_cnt} !== 14'h0) begin n_bad++; $display("FAIL async_data: got %h expected 0", {op_a, op_b, result, test_cnt}); end
    n_cmp++; if ({busy, all_done, timeout_err, gcd_start, result_valid} !== 5'b0) begin n_bad++; $display("FAIL async_ctrl: got %b expected 00000", {busy, all_done, timeout_err, gcd_start, result_valid}); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pulse_start();
    wait_issue(1, n);
    n_cmp++; if (n != 9) begin n_bad++; $display("FAIL reseed_issue_cycle: got %0d expected 9", n); end
    n_cmp++; if ({op_a, op_b} !== 8'hF3) begin n_bad++; $display("FAIL reseed_ops: got %h expected f3", {op_a, op_b}); end
  endtask

  task automatic test_zero_guard();
    int n;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 1;
    while (gcd_start2 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_cmp++; if (n != 5) begin n_bad++; $display("FAIL zg_issue_cycle: got %0d expected 5", n); end
    n_cmp++; if ({op_a2, op_b2} !== 4'hF) begin n_bad++; $display("FAIL zg_first_ops: got %h expected f", {op_a2, op_b2}); end
    @(negedge clk);
    gcd_done2 = 1'b1; gcd_result2 = 2'd3;
    @(negedge clk);
    gcd_done2 = 1'b0;
    n_cmp++; if ({result_valid2, result2} !== 3'b111) begin n_bad++; $display("FAIL zg_capture: got %b expected 111", {result_valid2, result2}); end
    n = 1;
    while (gcd_start2 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_cmp++; if (n != 5) begin n_bad++; $display("FAIL zg_second_cycle: got %0d expected 5", n); end
    n_cmp++; if (op_a2 !== 2'd3) begin n_bad++; $display("FAIL zg_op_a: got %0d expected 3", op_a2); end
    n_cmp++; if (op_b2 !== 2'd1) begin n_bad++; $display("FAIL zero_guard_op_b: got %0d expected 1", op_b2); end
    @(negedge clk);
    gcd_done2 = 1'b1; gcd_result2 = 2'd1;
    @(negedge clk);
    gcd_done2 = 1'b0;
    n_cmp++; if ({all_done2, test_cnt2} !== 3'b110) begin n_bad++; $display("FAIL zg_done: got %b expected 110", {all_done2, test_cnt2}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_coincident();
    test_async_reset();
    test_zero_guard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
